// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t    : boot/run/halt FSM encoding
//   NOP        : default bubble instruction (sll $0,$0,0)
//   WORD_ALIGN : low PC bits forced onto redirect targets
package fetch_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam logic [1:0]  WORD_ALIGN = 2'b00;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage signal bundle.
//   master : environment side (hazard unit, decode, imem) -- drives controls and imem data
//   slave  : fetch_stage side -- drives imem address, IF/ID contents, status and counters
interface fetch_if #(parameter int CNT_W = 16);
  logic             PCSTOP;
  logic             IDIF;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             halt_req;
  logic [31:0]      imem_rdata;
  logic [31:0]      imem_addr;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output PCSTOP, IDIF, redirect_valid, redirect_pc, halt_req, imem_rdata,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, stall_cycles, flush_count
  );

  modport slave (
    input  PCSTOP, IDIF, redirect_valid, redirect_pc, halt_req, imem_rdata,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   Clk, Rst_n         : clock, async active-low reset
//   flush              : load a bubble (instr=NOP_INSTR, pc4=0, valid=0); beats load
//   load               : capture instr_in / pc4_in and mark valid
//   instr, pc4, valid  : registered IF/ID contents
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run/halt FSM, next-PC selection,
// IF/ID register and saturating stall/flush counters.
//   Clk, Rst_n : clock, async active-low reset
//   bus        : fetch_if.slave -- hazard controls (PCSTOP, IDIF), decode redirect,
//                halt_req, imem port, IF/ID outputs, halted, counters
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP,
  parameter int          CNT_W     = 16
) (
  input  logic   Clk,
  input  logic   Rst_n,
  fetch_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             ifid_flush;
  logic             ifid_load;

  assign pc_plus4 = pc + 32'd4;   // wraps naturally at 2^32

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc    <= RESET_PC;
          state <= RUN;
        end
        RUN: begin
          // Redirect beats PCSTOP; a stalled cycle is only counted when no redirect.
          if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[31:2], WORD_ALIGN};
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
          end else if (bus.PCSTOP) begin
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
          end else begin
            pc <= pc_plus4;
          end
          if (bus.halt_req && !bus.PCSTOP) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (!bus.halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Outside RUN the IF/ID register only ever takes bubbles.
  assign ifid_flush = (state != RUN) || bus.redirect_valid;
  assign ifid_load  = bus.IDIF;

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .flush    (ifid_flush),
    .load     (ifid_load),
    .instr_in (bus.imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (bus.ifid_instr),
    .pc4      (bus.ifid_pc4),
    .valid    (bus.ifid_valid)
  );

  assign bus.imem_addr    = pc;
  assign bus.halted       = halted;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a cycle-level reference model of the
// fetch rules checked every negedge, and literal expectations at key points.
module tb_fetch_stage;
  localparam int CW = 4;   // narrow counters so saturation is reachable
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  fetch_if #(.CNT_W(CW)) bus();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(CW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign bus.imem_rdata = memword(bus.imem_addr);

  // Reference model: mode 0=boot, 1=run, 2=halt
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [CW-1:0] m_stall, m_flush;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_stall = '0; m_flush = '0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      m_pc = 32'h0; bubble(); m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        bubble();
        if (m_flush != CMAX) m_flush = m_flush + 1'b1;
      end else begin
        if (bus.IDIF) begin
          m_instr = memword(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        if (bus.PCSTOP) begin
          if (m_stall != CMAX) m_stall = m_stall + 1'b1;
        end else m_pc = m_pc + 32'd4;
      end
      if (bus.halt_req && !bus.PCSTOP) m_mode = 2;
    end else begin
      bubble();
      if (!bus.halt_req) m_mode = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle; inputs held stable across the edge, model advanced at it.
  task automatic step(input logic pcstop, input logic idif, input logic rv,
                      input logic [31:0] rp, input logic hr);
    bus.PCSTOP = pcstop; bus.IDIF = idif; bus.redirect_valid = rv;
    bus.redirect_pc = rp; bus.halt_req = hr;
    @(posedge Clk);
    model_step();
    #1;
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_pc",     bus.imem_addr, m_pc);
      chk("m_instr",  bus.ifid_instr, m_instr);
      chk("m_valid",  {31'd0, bus.ifid_valid}, {31'd0, m_valid});
      if (m_valid) chk("m_pc4", bus.ifid_pc4, m_pc4);
      chk("m_halted", {31'd0, bus.halted}, {31'd0, (m_mode == 2)});
      chk("m_stall",  {28'd0, bus.stall_cycles}, {28'd0, m_stall});
      chk("m_flush",  {28'd0, bus.flush_count}, {28'd0, m_flush});
    end
  end

  initial begin
    bus.PCSTOP = 0; bus.IDIF = 1; bus.redirect_valid = 0;
    bus.redirect_pc = 32'h0; bus.halt_req = 0;
    model_reset();
    #2;
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst_instr", bus.ifid_instr, 32'h0);
    chk("rst_halt",  {31'd0, bus.halted}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1; chk_en = 1'b1;

    // BOOT then first fetch
    step(0, 1, 0, 0, 0);
    chk("boot_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("boot_addr",  bus.imem_addr, 32'h0);
    step(0, 1, 0, 0, 0);
    chk("f1_addr",  bus.imem_addr, 32'h4);
    chk("f1_instr", bus.ifid_instr, 32'h8C00_0000);
    chk("f1_pc4",   bus.ifid_pc4, 32'h4);
    chk("f1_valid", {31'd0, bus.ifid_valid}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);   // PC -> 0x10

    // Stall 3 cycles with IF/ID held
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("st_addr",  bus.imem_addr, 32'h10);
    chk("st_instr", bus.ifid_instr, 32'h8C00_000C);
    chk("st_pc4",   bus.ifid_pc4, 32'h10);
    chk("st_cnt",   {28'd0, bus.stall_cycles}, 32'd3);
    step(0, 1, 0, 0, 0);
    chk("st_rel",   bus.imem_addr, 32'h14);

    // Redirect beats PCSTOP, low bits dropped
    step(1, 1, 1, 32'h43, 0);
    chk("rd_addr",  bus.imem_addr, 32'h40);
    chk("rd_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rd_instr", bus.ifid_instr, 32'h0);
    chk("rd_flush", {28'd0, bus.flush_count}, 32'd1);
    chk("rd_stall", {28'd0, bus.stall_cycles}, 32'd3);

    // Mixed patterns: duplicate latch, dropped fetch, normal
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // PC wrap
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, 0, 0);
    chk("wr_addr",  bus.imem_addr, 32'h0);
    chk("wr_pc4",   bus.ifid_pc4, 32'h0);
    chk("wr_instr", bus.ifid_instr, 32'h73FF_FFFC);

    // Halt at 0x20, redirect ignored while halted
    step(0, 1, 1, 32'h20, 0);
    step(0, 1, 0, 0, 1);
    chk("h_addr",  bus.imem_addr, 32'h24);
    chk("h_instr", bus.ifid_instr, 32'h8C00_0020);
    chk("h_halt",  {31'd0, bus.halted}, 32'd1);
    step(0, 1, 0, 0, 1);
    step(1, 1, 1, 32'h80, 1);
    step(0, 1, 0, 0, 1);
    chk("hh_addr",  bus.imem_addr, 32'h24);
    chk("hh_valid", {31'd0, bus.ifid_valid}, 32'd0);
    step(0, 1, 0, 0, 0);
    chk("hr_halt", {31'd0, bus.halted}, 32'd0);
    step(0, 1, 0, 0, 0);
    chk("hr_addr",  bus.imem_addr, 32'h28);
    chk("hr_instr", bus.ifid_instr, 32'h8C00_0024);

    // Stall counter saturation
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
    chk("sat_stall", {28'd0, bus.stall_cycles}, {28'd0, CMAX});
    step(0, 1, 0, 0, 0);

    // Asynchronous reset mid-stream
    chk_en = 1'b0;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_addr",  bus.imem_addr, 32'h0);
    chk("ar_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("ar_instr", bus.ifid_instr, 32'h0);
    chk("ar_pc4",   bus.ifid_pc4, 32'h0);
    chk("ar_stall", {28'd0, bus.stall_cycles}, 32'd0);
    chk("ar_flush", {28'd0, bus.flush_count}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1; chk_en = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("ar_f1", bus.imem_addr, 32'h4);

    @(negedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS datapath.
- Owns the PC and drives the instruction-memory address; imem read is combinational.
- Latches instruction and PC+4 into IF/ID for decode.
- Consumes the hazard unit's PCSTOP/IDIF stall outputs and decode's branch/jump redirect.
- Provides a boot/run/halt FSM and saturating stall/flush performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble instruction injected into IF/ID (sll $0,$0,0)
CNT_W, 16, width of each performance counter

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
PCSTOP  in  1  1 = hold PC this cycle (from hazard unit)
IDIF  in  1  1 = IF/ID may load; 0 = hold IF/ID (from hazard unit)
redirect_valid  in  1  taken branch/jump resolved in decode
redirect_pc  in  32  target address; bits [1:0] ignored, forced to 00
halt_req  in  1  level request to stop fetching
imem_rdata  in  32  instruction at imem_addr (combinational)
imem_addr  out  32  current PC, word aligned
ifid_instr  out  32  IF/ID instruction
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
halted  out  1  FSM is in HALT
stall_cycles  out  CNT_W  cycles with PCSTOP=1 while in RUN, saturating
flush_count  out  CNT_W  number of redirect flushes, saturating

Behaviour:
Reset (Rst_n=0, asynchronous):
- PC=RESET_PC; ifid_instr=NOP_INSTR; ifid_pc4=0; ifid_valid=0; halted=0; counters=0; state=BOOT.
- Reset mid-operation discards IF/ID contents and any pending redirect.

FSM states:
- BOOT: one cycle. PC held at RESET_PC; IF/ID loads a bubble. Always -> RUN next cycle.
- RUN: normal fetch. -> HALT when halt_req=1 and PCSTOP=0 at a clock edge. The instruction fetched that cycle is still latched into IF/ID.
- HALT: PC frozen; IF/ID loads a bubble every cycle; halted=1. -> RUN when halt_req=0 (no resumption penalty: PC fetch restarts next cycle). Redirects are ignored in HALT.

Next-PC priority in RUN, highest first:
1. redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (flush); flush_count++. Redirect wins over PCSTOP and IDIF=0.
2. PCSTOP=1: PC holds.
3. Otherwise: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).

IF/ID load in RUN, with no redirect:
- IDIF=1: ifid_instr <= imem_rdata; ifid_pc4 <= PC+4; ifid_valid <= 1.
- IDIF=0: all IF/ID fields hold.
- PCSTOP=1 with IDIF=1 is legal: the same instruction is re-latched, giving an idempotent duplicate.
- PCSTOP=0 with IDIF=0 is legal: a fetched instruction is dropped. The bench only checks the register rule.

General rules:
- Latency: instruction at PC appears on ifid_instr one edge after PC is presented, given IDIF=1.
- Counters saturate at all-ones, with no wrap. stall_cycles counts only in RUN with PCSTOP=1 and redirect_valid=0.
- All outputs are registered except imem_addr, which equals the PC register.

Decomposition:
- Shared package fetch_pkg: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), NOP constant, word-align helper constant 2'b00.
- One natural sub-module, ifid_reg: IF/ID register with load-enable, flush and async reset. The PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset release with RESET_PC=0 and imem returning addr-based words -> cycle 1 BOOT: ifid_valid=0. Cycle 2: imem_addr=4, ifid_instr=mem[0], ifid_pc4=4, ifid_valid=1.
- PCSTOP=1, IDIF=0 for 3 cycles at PC=0x10 -> PC stays 0x10, IF/ID unchanged, stall_cycles=3. Release -> PC=0x14 next edge.
- redirect_valid=1, redirect_pc=0x43 while PCSTOP=1 -> PC=0x40, ifid_valid=0, ifid_instr=0, flush_count=1.
- PC=0xFFFF_FFFC, no stall -> next PC=0x0000_0000, ifid_pc4=0.
- halt_req=1 at PC=0x20 -> the instruction at 0x20 is latched; halted=1 and PC frozen at 0x24 with bubbles. Drop halt_req -> fetch resumes at 0x24.
- Assert Rst_n=0 mid-stream with ifid_valid=1 and counters nonzero -> all outputs return to reset values immediately, without waiting for Clk.
